// File: rtl/hs_fifo_buf_if.sv
// hs_fifo_buf_if
// Purpose : groups the sender-side and receiver-side four-phase req/ack/data
//           channels of hs_fifo_buf into a single bundle.
// Signals : s_req, s_data  sender request and data (sender -> buffer)
//           s_ack          acknowledge to sender   (buffer -> sender)
//           r_req, r_data  request and data to receiver (buffer -> receiver)
//           r_ack          receiver acknowledge   (receiver -> buffer)
// Modports: slave  - the buffer itself
//           master - the environment driving sender and receiver
interface hs_fifo_buf_if #(
    parameter int WIDTH = 32
);
    logic             s_req;
    logic [WIDTH-1:0] s_data;
    logic             s_ack;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_ack;

    modport slave (
        input  s_req,
        input  s_data,
        output s_ack,
        output r_req,
        output r_data,
        input  r_ack
    );

    modport master (
        output s_req,
        output s_data,
        input  s_ack,
        input  r_req,
        input  r_data,
        output r_ack
    );
endinterface

// File: rtl/hs_fifo_buf.sv
// hs_fifo_buf
// Purpose : DEPTH-entry FIFO between a four-phase sender channel and a
//           four-phase receiver channel, fully synchronous to clk. The sender
//           can run up to DEPTH words ahead of the receiver.
// Ports   : clk    clock, all state changes on posedge
//           rst    asynchronous active-high reset, flushes contents and
//                  aborts both handshakes
//           bus    hs_fifo_buf_if.slave (s_req/s_data/s_ack, r_req/r_data/r_ack)
//           level  number of occupied entries, 0..DEPTH
//           full   level == DEPTH
//           empty  level == 0
//           push_cnt, pop_cnt  16-bit wrapping push/pop counters, only
//                  present when HS_FIFO_BUF_STATS_EN is defined
// Config  : define HS_FIFO_BUF_STATS_EN to add the statistics counters.
module hs_fifo_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    hs_fifo_buf_if.slave    bus,
    output logic [LW-1:0]   level,
    output logic            full,
    output logic            empty
`ifdef HS_FIFO_BUF_STATS_EN
    ,
    output logic [15:0]     push_cnt,
    output logic [15:0]     pop_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT
    } out_state_t;

    in_state_t        in_state_q, in_state_d;
    out_state_t       out_state_q, out_state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             s_ack_q, s_ack_d;
    logic             r_req_q, r_req_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             push;
    logic             pop;
    logic             full_w;
    logic             empty_w;

    // full/empty come from the registered level, so a push offered on the
    // same edge as a pop from a full FIFO is refused and lands one edge later.
    assign full_w  = (level_q == LW'(DEPTH));
    assign empty_w = (level_q == '0);

    // Input FSM: accept a word on the first edge where s_req is seen while
    // not full, then hold s_ack until the sender withdraws s_req.
    always_comb begin
        in_state_d = in_state_q;
        s_ack_d    = s_ack_q;
        push       = 1'b0;
        case (in_state_q)
            S_IDLE: begin
                if (bus.s_req && !full_w) begin
                    push       = 1'b1;
                    s_ack_d    = 1'b1;
                    in_state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!bus.s_req) begin
                    s_ack_d    = 1'b0;
                    in_state_d = S_IDLE;
                end
            end
            default: begin
                s_ack_d    = 1'b0;
                in_state_d = S_IDLE;
            end
        endcase
    end

    // Output FSM: present the head word with r_req, pop when the receiver
    // acknowledges, then wait for r_ack to fall before offering the next word.
    // r_data is only reloaded in R_IDLE so it stays put after the pop.
    always_comb begin
        out_state_d = out_state_q;
        r_req_d     = r_req_q;
        r_data_d    = r_data_q;
        pop         = 1'b0;
        case (out_state_q)
            R_IDLE: begin
                if (!empty_w) begin
                    r_data_d    = mem_q[rd_ptr_q];
                    r_req_d     = 1'b1;
                    out_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (bus.r_ack) begin
                    pop         = 1'b1;
                    r_req_d     = 1'b0;
                    out_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (!bus.r_ack) begin
                    out_state_d = R_IDLE;
                end
            end
            default: begin
                r_req_d     = 1'b0;
                out_state_d = R_IDLE;
            end
        endcase
    end

    // Pointers wrap naturally at DEPTH (a power of two); level tracks the
    // occupancy separately so full and empty never alias.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= S_IDLE;
            out_state_q <= R_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            s_ack_q     <= 1'b0;
            r_req_q     <= 1'b0;
            r_data_q    <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            s_ack_q     <= s_ack_d;
            r_req_q     <= r_req_d;
            r_data_q    <= r_data_d;
        end
    end

    // Storage array needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ack  = s_ack_q;
    assign bus.r_req  = r_req_q;
    assign bus.r_data = r_data_q;
    assign level      = level_q;
    assign full       = full_w;
    assign empty      = empty_w;

`ifdef HS_FIFO_BUF_STATS_EN
    logic [15:0] push_cnt_q;
    logic [15:0] pop_cnt_q;

    // Free-running 16-bit counters of accepted pushes and pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_q + 16'(push);
            pop_cnt_q  <= pop_cnt_q + 16'(pop);
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
`endif
endmodule

// File: tb/tb_hs_fifo_buf.sv
// tb_hs_fifo_buf
// Purpose : self-checking bench for hs_fifo_buf (WIDTH=32, DEPTH=4). The
//           reference model is a queue of words the sender has had
//           acknowledged; every word the receiver collects must match the
//           queue head. Covers reset values, single-word latency, fill and
//           stall, push/pop on the same edge, a 100-word randomized stream
//           and reset in the middle of a handshake.
// Config  : HS_FIFO_BUF_STATS_EN also checks push_cnt/pop_cnt.
module tb_hs_fifo_buf;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH + 1);
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
`ifdef HS_FIFO_BUF_STATS_EN
    logic [15:0]   push_cnt;
    logic [15:0]   pop_cnt;
`endif

    hs_fifo_buf_if #(.WIDTH(WIDTH)) bus ();

    hs_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .level (level),
        .full  (full),
        .empty (empty)
`ifdef HS_FIFO_BUF_STATS_EN
        ,
        .push_cnt (push_cnt),
        .pop_cnt  (pop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] modelQ[$];
    int          pushTotal  = 0;
    int          popTotal   = 0;

    // One comparison of an observed DUT value against a bench-computed value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // An expired wait bound counts as a failed comparison.
    task automatic timeoutFail(input string tag);
        compared++;
        mismatched++;
        $error("[TB] FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Sender side: full four-phase transfer of one word after 'gap' idle cycles.
    task automatic applyStimulus(input logic [31:0] d, input int gap);
        bit got;
        repeat (gap) @(negedge clk);
        bus.s_req  = 1'b1;
        bus.s_data = d;
        got = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (bus.s_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        bus.s_req = 1'b0;
        if (!got) begin
            timeoutFail("push_ack_rise");
            return;
        end
        modelQ.push_back(d);
        pushTotal++;
        got = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (bus.s_ack === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeoutFail("push_ack_fall");
    endtask

    // Receiver side: wait for r_req, compare with model head, ack after delay.
    task automatic popAndCheck(input string tag, input int delay);
        bit          got;
        logic [31:0] exp;
        got = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            if (bus.r_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            timeoutFail({tag, "_req"});
            return;
        end
        if (modelQ.size() == 0) begin
            timeoutFail({tag, "_unexpected_word"});
            exp = 'x;
        end else begin
            exp = modelQ.pop_front();
        end
        checkOutput(tag, 64'(bus.r_data), 64'(exp));
        repeat (delay) @(negedge clk);
        bus.r_ack = 1'b1;
        got = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (bus.r_req === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        bus.r_ack = 1'b0;
        if (!got) begin
            timeoutFail({tag, "_req_fall"});
            return;
        end
        popTotal++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b, c;
        bit          sawAck;

        // Reset held: all outputs at their reset values.
        rst        = 1'b1;
        bus.s_req  = 1'b0;
        bus.s_data = '0;
        bus.r_ack  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_s_ack", 64'(bus.s_ack), 64'd0);
        checkOutput("rst_r_req", 64'(bus.r_req), 64'd0);
        checkOutput("rst_r_data", 64'(bus.r_data), 64'd0);
        checkOutput("rst_level", 64'(level), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_empty", 64'(empty), 64'd1);
`ifdef HS_FIFO_BUF_STATS_EN
        checkOutput("rst_push_cnt", 64'(push_cnt), 64'd0);
        checkOutput("rst_pop_cnt", 64'(pop_cnt), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single word, cycle by cycle: ack one cycle after req, r_req one later.
        bus.s_req  = 1'b1;
        bus.s_data = 32'h0000_0005;
        @(negedge clk);
        checkOutput("single_s_ack", 64'(bus.s_ack), 64'd1);
        checkOutput("single_r_req_early", 64'(bus.r_req), 64'd0);
        checkOutput("single_level1", 64'(level), 64'd1);
        bus.s_req = 1'b0;
        @(negedge clk);
        checkOutput("single_r_req", 64'(bus.r_req), 64'd1);
        checkOutput("single_r_data", 64'(bus.r_data), 64'h5);
        checkOutput("single_s_ack_fall", 64'(bus.s_ack), 64'd0);
        bus.r_ack = 1'b1;
        @(negedge clk);
        checkOutput("single_r_req_fall", 64'(bus.r_req), 64'd0);
        checkOutput("single_level0", 64'(level), 64'd0);
        checkOutput("single_r_data_hold", 64'(bus.r_data), 64'h5);
        bus.r_ack = 1'b0;
        pushTotal++;
        popTotal++;
        @(negedge clk);

        // Fill with r_ack held low, then a fifth request must stall.
        for (int i = 0; i < DEPTH; i++) applyStimulus(32'(i), 0);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_level", 64'(level), 64'(DEPTH));
        bus.s_req  = 1'b1;
        bus.s_data = 32'd4;
        sawAck = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.s_ack !== 1'b0) sawAck = 1'b1;
        end
        checkOutput("fill_stall_no_ack", 64'(sawAck), 64'd0);
        checkOutput("fill_head_req", 64'(bus.r_req), 64'd1);
        checkOutput("fill_head_data", 64'(bus.r_data), 64'(modelQ[0]));
        // Pop while the push is pending: push is refused on the pop edge.
        bus.r_ack = 1'b1;
        @(negedge clk);
        void'(modelQ.pop_front());
        popTotal++;
        checkOutput("fill_pop_level", 64'(level), 64'(DEPTH - 1));
        checkOutput("fill_pop_no_ack", 64'(bus.s_ack), 64'd0);
        @(negedge clk);
        checkOutput("fill_late_ack", 64'(bus.s_ack), 64'd1);
        checkOutput("fill_late_level", 64'(level), 64'(DEPTH));
        modelQ.push_back(32'd4);
        pushTotal++;
        bus.r_ack = 1'b0;
        bus.s_req = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) popAndCheck("drain", $urandom_range(0, 3));
        checkOutput("drain_empty", 64'(empty), 64'd1);

        // Simultaneous push and pop at level 2.
        a = $urandom;
        b = $urandom;
        c = $urandom;
        applyStimulus(a, 0);
        applyStimulus(b, 0);
        checkOutput("simul_level_before", 64'(level), 64'd2);
        checkOutput("simul_head_a", 64'(bus.r_data), 64'(a));
        bus.r_ack  = 1'b1;
        bus.s_req  = 1'b1;
        bus.s_data = c;
        @(negedge clk);
        checkOutput("simul_level_after", 64'(level), 64'd2);
        checkOutput("simul_s_ack", 64'(bus.s_ack), 64'd1);
        checkOutput("simul_r_req", 64'(bus.r_req), 64'd0);
        void'(modelQ.pop_front());
        popTotal++;
        modelQ.push_back(c);
        pushTotal++;
        bus.r_ack = 1'b0;
        bus.s_req = 1'b0;
        repeat (2) @(negedge clk);
        popAndCheck("simul_head_b", 0);
        popAndCheck("simul_tail_c", 1);

        // 100 random words, random sender gaps, receiver acks after 3 cycles.
        fork
            begin
                for (int i = 0; i < 100; i++) applyStimulus($urandom, $urandom_range(0, 3));
            end
            begin
                for (int i = 0; i < 100; i++) popAndCheck("stream", 3);
            end
        join
        checkOutput("stream_model_empty", 64'(modelQ.size()), 64'd0);
        checkOutput("stream_level", 64'(level), 64'd0);
        checkOutput("stream_empty", 64'(empty), 64'd1);
`ifdef HS_FIFO_BUF_STATS_EN
        checkOutput("stats_push_cnt", 64'(push_cnt), 64'(pushTotal));
        checkOutput("stats_pop_cnt", 64'(pop_cnt), 64'(popTotal));
`endif

        // Reset while r_req is waiting for r_ack, between clock edges.
        applyStimulus($urandom, 0);
        applyStimulus($urandom, 0);
        sawAck = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (bus.r_req === 1'b1) begin
                sawAck = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!sawAck) timeoutFail("midrst_wait_req");
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_r_req", 64'(bus.r_req), 64'd0);
        checkOutput("midrst_s_ack", 64'(bus.s_ack), 64'd0);
        checkOutput("midrst_r_data", 64'(bus.r_data), 64'd0);
        checkOutput("midrst_level", 64'(level), 64'd0);
        checkOutput("midrst_empty", 64'(empty), 64'd1);
`ifdef HS_FIFO_BUF_STATS_EN
        checkOutput("midrst_push_cnt", 64'(push_cnt), 64'd0);
        checkOutput("midrst_pop_cnt", 64'(pop_cnt), 64'd0);
`endif
        modelQ.delete();
        pushTotal = 0;
        popTotal  = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // The buffer works normally after the flush.
        applyStimulus($urandom, 0);
        popAndCheck("post_rst", 0);
        checkOutput("post_rst_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
